// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: branch flush, multi-cycle EX stall and load-use stall.
// Optional statistics counters enabled by defining HAZARD_STATS_EN.
module pipeline_hazard_ctrl #(
   parameter int unsigned MC_LAT = 4
) (
   input  logic        Clk,
   input  logic        Rst,
   input  logic [4:0]  d_rs,
   input  logic [4:0]  d_rt,
   input  logic        d_uses_rt,
   input  logic        x_memread,
   input  logic [4:0]  x_rd,
   input  logic        x_branch_taken,
   input  logic        x_mc_start,
   output logic        pc_write,
   output logic        fd_write,
   output logic        fd_deactivate,
   output logic        dx_write,
   output logic        dx_deactivate,
   output logic        xm_deactivate,
   output logic [15:0] stall_cycles,
   output logic [15:0] flush_events
);

   typedef enum logic {RUN, BUSY} state_t;

   localparam logic [3:0] CNT_LOAD = 4'(MC_LAT - 1);

   state_t     state_q, state_d;
   logic [3:0] cnt_q, cnt_d;
   logic       load_use;

   assign load_use = x_memread && (x_rd != 5'd0) &&
                     ((x_rd == d_rs) || (d_uses_rt && (x_rd == d_rt)));

   // NOTE: non-blocking assignments in clocked blocks so every flop samples pre-edge values.
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         state_q <= RUN;
         cnt_q   <= 4'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // NOTE: every output and next-state signal gets a default first so no path infers a latch.
   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      pc_write      = 1'b1;
      fd_write      = 1'b1;
      fd_deactivate = 1'b0;
      dx_write      = 1'b1;
      dx_deactivate = 1'b0;
      xm_deactivate = 1'b0;

      if (Rst) begin
         pc_write      = 1'b0;
         fd_write      = 1'b0;
         dx_write      = 1'b0;
         fd_deactivate = 1'b1;
         dx_deactivate = 1'b1;
         xm_deactivate = 1'b1;
      end else begin
         unique case (state_q)
            RUN: begin
               if (x_branch_taken) begin
                  fd_deactivate = 1'b1;
                  dx_deactivate = 1'b1;
               end else if (x_mc_start) begin
                  pc_write      = 1'b0;
                  fd_write      = 1'b0;
                  dx_write      = 1'b0;
                  xm_deactivate = 1'b1;
                  state_d       = BUSY;
                  cnt_d         = CNT_LOAD;
               end else if (load_use) begin
                  pc_write      = 1'b0;
                  fd_write      = 1'b0;
                  dx_deactivate = 1'b1;
               end
            end
            BUSY: begin
               // The final occupancy cycle releases the pipeline; starts seen here are ignored.
               if (cnt_q > 4'd1) begin
                  pc_write      = 1'b0;
                  fd_write      = 1'b0;
                  dx_write      = 1'b0;
                  xm_deactivate = 1'b1;
                  cnt_d         = cnt_q - 4'd1;
               end else begin
                  state_d = RUN;
                  cnt_d   = 4'd0;
               end
            end
            default: begin
               state_d = RUN;
               cnt_d   = 4'd0;
            end
         endcase
      end
   end

`ifdef HAZARD_STATS_EN
   logic [15:0] stall_q, flush_q;

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         stall_q <= 16'd0;
         flush_q <= 16'd0;
      end else begin
         if (!pc_write && (stall_q != 16'hFFFF))
            stall_q <= stall_q + 16'd1;
         if ((state_q == RUN) && x_branch_taken && (flush_q != 16'hFFFF))
            flush_q <= flush_q + 16'd1;
      end
   end

   assign stall_cycles = stall_q;
   assign flush_events = flush_q;
`else
   assign stall_cycles = 16'd0;
   assign flush_events = 16'd0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl (MC_LAT=4): vector table plus reset/stats sequences.
module tb_pipeline_hazard_ctrl;

   logic        Clk, Rst;
   logic [4:0]  d_rs, d_rt, x_rd;
   logic        d_uses_rt, x_memread, x_branch_taken, x_mc_start;
   logic        pc_write, fd_write, fd_deactivate, dx_write, dx_deactivate, xm_deactivate;
   logic [15:0] stall_cycles, flush_events;

   pipeline_hazard_ctrl #(.MC_LAT(4)) dut (
      .Clk(Clk), .Rst(Rst),
      .d_rs(d_rs), .d_rt(d_rt), .d_uses_rt(d_uses_rt),
      .x_memread(x_memread), .x_rd(x_rd),
      .x_branch_taken(x_branch_taken), .x_mc_start(x_mc_start),
      .pc_write(pc_write), .fd_write(fd_write), .fd_deactivate(fd_deactivate),
      .dx_write(dx_write), .dx_deactivate(dx_deactivate), .xm_deactivate(xm_deactivate),
      .stall_cycles(stall_cycles), .flush_events(flush_events)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   // Output bundle order: {pc_write, fd_write, fd_deactivate, dx_write, dx_deactivate, xm_deactivate}
   localparam logic [5:0] O_DEF   = 6'b110100;
   localparam logic [5:0] O_MC    = 6'b000001;
   localparam logic [5:0] O_LU    = 6'b000110;
   localparam logic [5:0] O_BR    = 6'b111110;
   localparam logic [5:0] O_RST   = 6'b001011;

`ifdef HAZARD_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   typedef struct {
      string      name;
      logic [4:0] rs, rt;
      logic       uses_rt, memread;
      logic [4:0] rd;
      logic       br, mc;
      logic [5:0] exp;
   } vec_t;

   vec_t vecs[19];
   int   n_vec = 0;
   int   n_err = 0;

   function automatic logic [5:0] outs();
      return {pc_write, fd_write, fd_deactivate, dx_write, dx_deactivate, xm_deactivate};
   endfunction

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic uses_rt,
                        input logic memread, input logic [4:0] rd, input logic br, input logic mc);
      d_rs = rs; d_rt = rt; d_uses_rt = uses_rt;
      x_memread = memread; x_rd = rd; x_branch_taken = br; x_mc_start = mc;
   endtask

   function automatic vec_t mk(string n, logic [4:0] rs, logic [4:0] rt, logic ur, logic mr,
                               logic [4:0] rd, logic br, logic mc, logic [5:0] e);
      vec_t v;
      v.name = n; v.rs = rs; v.rt = rt; v.uses_rt = ur; v.memread = mr;
      v.rd = rd; v.br = br; v.mc = mc; v.exp = e;
      return v;
   endfunction

   initial begin
      vecs[0]  = mk("idle",            5'd1, 5'd2, 1'b1, 1'b0, 5'd3, 1'b0, 1'b0, O_DEF);
      vecs[1]  = mk("lu_rs",           5'd8, 5'd2, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0, O_LU);
      vecs[2]  = mk("lu_next_cycle",   5'd8, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, O_DEF);
      vecs[3]  = mk("lu_rt",           5'd1, 5'd9, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0, O_LU);
      vecs[4]  = mk("rt_not_used",     5'd1, 5'd9, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0, O_DEF);
      vecs[5]  = mk("no_memread",      5'd7, 5'd7, 1'b1, 1'b0, 5'd7, 1'b0, 1'b0, O_DEF);
      vecs[6]  = mk("rd_zero",         5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, O_DEF);
      vecs[7]  = mk("br_over_lu",      5'd5, 5'd1, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, O_BR);
      vecs[8]  = mk("br_over_mc",      5'd1, 5'd2, 1'b0, 1'b0, 5'd3, 1'b1, 1'b1, O_BR);
      vecs[9]  = mk("mc_over_lu",      5'd4, 5'd1, 1'b0, 1'b1, 5'd4, 1'b0, 1'b1, O_MC);
      vecs[10] = mk("busy3_br_ign",    5'd1, 5'd2, 1'b0, 1'b0, 5'd3, 1'b1, 1'b0, O_MC);
      vecs[11] = mk("busy2_lu_ign",    5'd6, 5'd1, 1'b0, 1'b1, 5'd6, 1'b0, 1'b0, O_MC);
      vecs[12] = mk("busy1_mc_ign",    5'd1, 5'd2, 1'b0, 1'b0, 5'd3, 1'b0, 1'b1, O_DEF);
      vecs[13] = mk("back_in_run_lu",  5'd6, 5'd1, 1'b0, 1'b1, 5'd6, 1'b0, 1'b0, O_LU);
      vecs[14] = mk("mc2_start",       5'd1, 5'd2, 1'b0, 1'b0, 5'd3, 1'b0, 1'b1, O_MC);
      vecs[15] = mk("mc2_busy3",       5'd1, 5'd2, 1'b0, 1'b0, 5'd3, 1'b0, 1'b1, O_MC);
      vecs[16] = mk("mc2_busy2",       5'd1, 5'd2, 1'b0, 1'b0, 5'd3, 1'b0, 1'b1, O_MC);
      vecs[17] = mk("mc2_busy1",       5'd1, 5'd2, 1'b0, 1'b0, 5'd3, 1'b0, 1'b1, O_DEF);
      vecs[18] = mk("run_after_mc2",   5'd1, 5'd2, 1'b0, 1'b0, 5'd3, 1'b1, 1'b0, O_BR);

      // Reset state
      Rst = 1'b1;
      drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
      #1;
      check("reset_outs", 16'(outs()), 16'(O_RST));
      check("reset_stall_cnt", stall_cycles, 16'd0);
      check("reset_flush_cnt", flush_events, 16'd0);
      @(negedge Clk);
      @(negedge Clk);
      Rst = 1'b0;
      #1 check("post_reset_default", 16'(outs()), 16'(O_DEF));

      // Vector table, one vector per clock cycle
      for (int i = 0; i < 19; i++) begin
         @(negedge Clk);
         drive(vecs[i].rs, vecs[i].rt, vecs[i].uses_rt, vecs[i].memread,
               vecs[i].rd, vecs[i].br, vecs[i].mc);
         #1 check(vecs[i].name, 16'(outs()), 16'(vecs[i].exp));
      end
      @(negedge Clk);
      drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
      #1;
      check("table_stall_cnt", stall_cycles, STATS ? 16'd9 : 16'd0);
      check("table_flush_cnt", flush_events, STATS ? 16'd3 : 16'd0);

      // Reset asserted mid-BUSY with cnt=2
      @(negedge Clk);
      x_mc_start = 1'b1;
      #1 check("rb_start", 16'(outs()), 16'(O_MC));
      @(negedge Clk);
      x_mc_start = 1'b0;
      #1 check("rb_cnt3", 16'(outs()), 16'(O_MC));
      @(negedge Clk);
      #1 check("rb_cnt2", 16'(outs()), 16'(O_MC));
      #1 Rst = 1'b1;
      #1;
      check("rb_async_outs", 16'(outs()), 16'(O_RST));
      check("rb_async_stall_clr", stall_cycles, 16'd0);
      @(negedge Clk);
      Rst = 1'b0;
      #1 check("rb_release", 16'(outs()), 16'(O_DEF));
      for (int i = 0; i < 4; i++) begin
         @(negedge Clk);
         #1 check("rb_no_residual", 16'(outs()), 16'(O_DEF));
      end

      // Statistics: two branches plus one MC_LAT=4 op
      @(negedge Clk);
      x_branch_taken = 1'b1;
      #1 check("st_br1", 16'(outs()), 16'(O_BR));
      @(negedge Clk);
      #1 check("st_br2", 16'(outs()), 16'(O_BR));
      @(negedge Clk);
      x_branch_taken = 1'b0;
      x_mc_start = 1'b1;
      #1 check("st_mc", 16'(outs()), 16'(O_MC));
      @(negedge Clk);
      x_mc_start = 1'b0;
      @(negedge Clk);
      @(negedge Clk);
      #1 check("st_mc_done", 16'(outs()), 16'(O_DEF));
      @(negedge Clk);
      #1;
      check("st_flush_cnt", flush_events, STATS ? 16'd2 : 16'd0);
      check("st_stall_cnt", stall_cycles, STATS ? 16'd3 : 16'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 SHALL have parameter: MC_LAT, default 4, total EX-stage occupancy in cycles of a multi-cycle op (legal range 2..15).
REQ-002 SHALL have ports as follows, one per line (name  direction  width  meaning):
  Clk  input  1  single clock, rising edge.
  Rst  input  1  reset, asynchronous, active-high.
  d_rs  input  5  source reg 1 of instruction in decode.
  d_rt  input  5  source reg 2 of instruction in decode.
  d_uses_rt  input  1  decode instruction reads d_rt.
  x_memread  input  1  instruction in EX is a load.
  x_rd  input  5  destination reg of instruction in EX.
  x_branch_taken  input  1  EX resolved a taken branch or jump this cycle.
  x_mc_start  input  1  multi-cycle op (mult/div) entered EX this cycle.
  pc_write  output  1  PC update enable.
  fd_write  output  1  F/D register load enable.
  fd_deactivate  output  1  flush F/D to zero at next edge.
  dx_write  output  1  D/X register load enable.
  dx_deactivate  output  1  flush D/X to zero at next edge.
  xm_deactivate  output  1  flush X/M to zero at next edge.
  stall_cycles  output  16  stall-cycle statistic.
  flush_events  output  16  taken-branch flush statistic.

Function
REQ-003 SHALL implement a two-state FSM, RUN and BUSY, plus a 4-bit down-counter cnt.
REQ-004 SHALL drive outputs combinationally from state, cnt and inputs; default (no event): pc_write=1, fd_write=1, dx_write=1, all deactivate=0.
REQ-005 SHALL, in RUN, evaluate events in the priority branch > multi-cycle start > load-use; only the highest active event takes effect.
REQ-006 Branch (RUN, x_branch_taken=1): fd_deactivate=1, dx_deactivate=1, pc_write=1; state stays RUN.
REQ-007 Multi-cycle start (RUN, x_mc_start=1, no branch): pc_write=0, fd_write=0, dx_write=0, xm_deactivate=1; next state BUSY, cnt loaded with MC_LAT-1.
REQ-008 BUSY with cnt>1: same stall outputs as REQ-007; cnt decrements by 1; x_branch_taken, x_mc_start and load-use ignored.
REQ-009 BUSY with cnt==1: default outputs (pipeline advances); next state RUN; total stall = MC_LAT-1 cycles, EX occupancy = MC_LAT cycles.
REQ-010 Load-use (RUN, no higher event): hazard when x_memread=1, x_rd!=0 and (x_rd==d_rs or (d_uses_rt=1 and x_rd==d_rt)); outputs pc_write=0, fd_write=0, dx_deactivate=1 for that cycle only; state stays RUN.
REQ-011 x_rd==0 SHALL never produce a load-use stall.
REQ-012 Back-to-back multi-cycle ops SHALL each receive a full MC_LAT occupancy; a start seen in the cnt==1 BUSY cycle is ignored (that op cannot be in EX yet).

Reset
REQ-013 Rst=1 SHALL immediately (asynchronously) force state=RUN, cnt=0, stall_cycles=0, flush_events=0.
REQ-014 While Rst=1, outputs SHALL be pc_write=0, fd_write=0, dx_write=0, fd_deactivate=1, dx_deactivate=1, xm_deactivate=1.
REQ-015 Rst asserted in BUSY SHALL abandon the stall; after release, operation resumes in RUN with default outputs.

Configuration
REQ-016 Macro HAZARD_STATS_EN defined: stall_cycles increments each non-reset cycle with pc_write=0; flush_events increments each cycle REQ-006 applies; both saturate at 0xFFFF.
REQ-017 Macro HAZARD_STATS_EN undefined: ports stall_cycles and flush_events remain present, tied to 0, no counter logic.

Verification
REQ-018 Load-use: x_memread=1, x_rd=8, d_rs=8 for one cycle -> pc_write=0, fd_write=0, dx_deactivate=1 that cycle only; next cycle defaults.
REQ-019 Multi-cycle, MC_LAT=4: x_mc_start pulse -> stall outputs asserted exactly 3 cycles, 4th cycle defaults, state back to RUN.
REQ-020 Priority: x_branch_taken=1 with load-use match on x_rd=5 -> fd_deactivate=1, dx_deactivate=1, pc_write=1, no stall.
REQ-021 Rst pulse mid-BUSY (cnt=2) -> reset outputs of REQ-014 immediately; after release, RUN defaults, no residual stall.
REQ-022 HAZARD_STATS_EN defined: two branches plus one MC_LAT=4 op -> flush_events=2, stall_cycles=3; undefined -> both read 0.
REQ-023 d_rs=0 with x_memread=1, x_rd=0 -> no stall, defaults maintained.
